// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the writeback requesters and the register-file write arbiter.
// The master side is the requesters/register file; the slave side is the arbiter.
interface regfile_write_arbiter_if #(
  parameter int NREQ   = 3,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic [NREQ-1:0]        inp_req_valid;
  logic [NREQ*ADDR_W-1:0] inp_req_addr;
  logic [NREQ*DATA_W-1:0] inp_req_data;
  logic [NREQ-1:0]        out_req_ready;
  logic                   inp_hold;
  logic                   inp_clr_stats;
  logic                   out_flagWrite;
  logic [ADDR_W-1:0]      out_regWrite;
  logic [DATA_W-1:0]      out_dataWrite;
  logic [(1<<ADDR_W)-1:0] out_pending;
  logic [7:0]             out_conflict_cnt;

  modport master (
    output inp_req_valid, inp_req_addr, inp_req_data, inp_hold, inp_clr_stats,
    input  out_req_ready, out_flagWrite, out_regWrite, out_dataWrite,
           out_pending, out_conflict_cnt
  );

  modport slave (
    input  inp_req_valid, inp_req_addr, inp_req_data, inp_hold, inp_clr_stats,
    output out_req_ready, out_flagWrite, out_regWrite, out_dataWrite,
           out_pending, out_conflict_cnt
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a registered
// write stage, a pending-write mask and a saturating contention counter.
module regfile_write_arbiter #(
  parameter int NREQ   = 3,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                   inp_clk,
  input  logic                   inp_rst_n,
  regfile_write_arbiter_if.slave bus
);
  localparam int PTR_W = (NREQ > 2) ? 2 : 1;
  localparam int NREG  = 1 << ADDR_W;

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  win;
  logic [PTR_W-1:0]  ptr_nxt;
  logic              found;
  logic [NREQ-1:0]   grant;
  logic              contended;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              flag_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [7:0]        cnt_q;
  logic [NREG-1:0]   pending;
  int                idx;
  int                nvalid;

  // Search starts at ptr and wraps; hold suppresses every grant.
  always_comb begin
    grant  = '0;
    found  = 1'b0;
    win    = '0;
    idx    = 0;
    nvalid = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!bus.inp_hold && !found && bus.inp_req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win        = PTR_W'(idx);
      end
      if (bus.inp_req_valid[i]) nvalid = nvalid + 1;
    end
    contended = !bus.inp_hold && (nvalid >= 2);
    win_addr  = bus.inp_req_addr[int'(win)*ADDR_W +: ADDR_W];
    win_data  = bus.inp_req_data[int'(win)*DATA_W +: DATA_W];
    ptr_nxt   = (int'(win) == NREQ - 1) ? '0 : win + PTR_W'(1);
  end

  always_ff @(posedge inp_clk or negedge inp_rst_n) begin
    if (!inp_rst_n) begin
      ptr    <= '0;
      flag_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      flag_q <= found;
      if (found) begin
        ptr    <= ptr_nxt;
        addr_q <= win_addr;
        data_q <= win_data;
      end
      if (bus.inp_clr_stats)
        cnt_q <= '0;
      else if (contended && cnt_q != 8'hFF)
        cnt_q <= cnt_q + 8'd1;
    end
  end

  always_comb begin
    pending = '0;
    if (flag_q) pending[addr_q] = 1'b1;
  end

  // Ready is forced low while reset is asserted, independent of the inputs.
  assign bus.out_req_ready    = grant & {NREQ{inp_rst_n}};
  assign bus.out_flagWrite    = flag_q;
  assign bus.out_regWrite     = addr_q;
  assign bus.out_dataWrite    = data_q;
  assign bus.out_pending      = pending;
  assign bus.out_conflict_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomized checks of the register-file write arbiter against a
// cycle-level behavioural model of the arbitration and write-stage rules.
module tb_regfile_write_arbiter;
  localparam int NREQ   = 3;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  logic clk;
  logic rst_n;

  regfile_write_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_write_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .inp_clk   (clk),
    .inp_rst_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus state per requester
  logic              rq_valid [NREQ];
  logic [ADDR_W-1:0] rq_addr  [NREQ];
  logic [DATA_W-1:0] rq_data  [NREQ];
  logic              hold;
  logic              clr;

  // Reference model
  int          m_ptr;
  logic        m_flag;
  int          m_addr;
  logic [15:0] m_data;
  int          m_cnt;
  logic [15:0] m_rf [8];
  int          last_grant;

  // Register file fed by the DUT write port
  logic [15:0] tb_rf [8] = '{default: 16'h0};
  always @(posedge clk)
    if (bus.out_flagWrite) tb_rf[bus.out_regWrite] <= bus.out_dataWrite;

  int vectors     = 0;
  int miscompares = 0;
  int n_checks    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.inp_req_valid[i] = rq_valid[i];
      bus.inp_req_addr[i*ADDR_W +: ADDR_W] = rq_addr[i];
      bus.inp_req_data[i*DATA_W +: DATA_W] = rq_data[i];
    end
    bus.inp_hold      = hold;
    bus.inp_clr_stats = clr;
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_flag = 1'b0;
    m_addr = 0;
    m_data = 16'h0;
    m_cnt  = 0;
  endtask

  task automatic check_outputs(input string pfx);
    logic [7:0] exp_pend;
    exp_pend = m_flag ? 8'(1 << m_addr) : 8'h00;
    chk({pfx, "_flag"}, 32'(bus.out_flagWrite), 32'(m_flag));
    chk({pfx, "_addr"}, 32'(bus.out_regWrite), 32'(m_addr));
    chk({pfx, "_data"}, 32'(bus.out_dataWrite), 32'(m_data));
    chk({pfx, "_pend"}, 32'(bus.out_pending), 32'(exp_pend));
    chk({pfx, "_cnt"},  32'(bus.out_conflict_cnt), 32'(m_cnt));
  endtask

  // One clock: drive, check ready before the edge, advance model, check registered outputs.
  task automatic cycle();
    int k, nv, j;
    logic [NREQ-1:0] exp_ready;
    drive();
    @(negedge clk);
    k  = -1;
    nv = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (m_ptr + i) % NREQ;
      if (!hold && k < 0 && rq_valid[j]) k = j;
      if (rq_valid[i]) nv++;
    end
    exp_ready = (k >= 0) ? NREQ'(1 << k) : '0;
    chk("ready", 32'(bus.out_req_ready), 32'(exp_ready));
    @(posedge clk);
    if (m_flag) m_rf[m_addr] = m_data;
    if (k >= 0) begin
      m_flag = 1'b1;
      m_addr = int'(rq_addr[k]);
      m_data = rq_data[k];
      m_ptr  = (k + 1) % NREQ;
    end else begin
      m_flag = 1'b0;
    end
    if (clr) m_cnt = 0;
    else if (!hold && nv >= 2) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
    last_grant = k;
    #1;
    check_outputs("out");
    vectors++;
  endtask

  task automatic set_req(input int i, input logic v, input int a, input logic [15:0] d);
    rq_valid[i] = v;
    rq_addr[i]  = ADDR_W'(a);
    rq_data[i]  = d;
  endtask

  initial begin
    for (int r = 0; r < 8; r++) m_rf[r] = 16'h0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 0, 16'h0);
    hold  = 1'b0;
    clr   = 1'b0;
    rst_n = 1'b0;
    drive();
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outputs("rst");
    chk("rst_ready", 32'(bus.out_req_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single write
    set_req(0, 1'b1, 3, 16'h1234);
    cycle();
    chk("single_flag", 32'(bus.out_flagWrite), 32'h1);
    chk("single_pend", 32'(bus.out_pending), 32'h08);
    set_req(0, 1'b0, 3, 16'h1234);
    cycle();
    chk("single_idle_pend", 32'(bus.out_pending), 32'h00);

    // Round-robin with continuous contention
    set_req(0, 1'b1, 0, 16'hA000);
    set_req(1, 1'b1, 1, 16'hB000);
    set_req(2, 1'b1, 4, 16'hC000);
    repeat (6) cycle();

    // Hold mid-stream
    hold = 1'b1;
    repeat (3) begin
      cycle();
      chk("hold_flag", 32'(bus.out_flagWrite), 32'h0);
    end
    hold = 1'b0;
    repeat (3) cycle();

    // Saturation and clear
    repeat (300) cycle();
    chk("sat_cnt", 32'(bus.out_conflict_cnt), 32'd255);
    clr = 1'b1;
    cycle();
    chk("clr_cnt", 32'(bus.out_conflict_cnt), 32'd0);
    clr = 1'b0;
    for (int i = 0; i < NREQ; i++) rq_valid[i] = 1'b0;
    cycle();

    // Async reset drops an accepted write
    rst_n = 1'b0;
    #2;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_req(1, 1'b1, 5, 16'hBEEF);
    cycle();
    chk("arst_acc_data", 32'(bus.out_dataWrite), 32'hBEEF);
    set_req(1, 1'b0, 5, 16'hBEEF);
    drive();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_flag", 32'(bus.out_flagWrite), 32'h0);
    chk("arst_pend", 32'(bus.out_pending), 32'h0);
    chk("arst_ready", 32'(bus.out_req_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Same address back-to-back, first grant after reset to lowest valid
    set_req(0, 1'b1, 2, 16'h1111);
    set_req(1, 1'b1, 2, 16'h2222);
    cycle();
    chk("same_first", 32'(bus.out_dataWrite), 32'h1111);
    set_req(0, 1'b0, 2, 16'h1111);
    cycle();
    chk("same_second", 32'(bus.out_dataWrite), 32'h2222);
    set_req(1, 1'b0, 2, 16'h2222);
    repeat (2) cycle();
    chk("rf_reg2", 32'(tb_rf[2]), 32'(m_rf[2]));
    chk("rf_reg2_val", 32'(tb_rf[2]), 32'h2222);
    chk("rf_reg5_dropped", 32'(tb_rf[5]), 32'h0);

    // Randomized traffic; requesters keep a request stable until it is granted
    for (int n = 0; n < 250; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!rq_valid[i] && $urandom_range(1, 0) == 1)
          set_req(i, 1'b1, int'($urandom_range(7, 0)), 16'($urandom));
      hold = ($urandom_range(7, 0) == 0);
      clr  = ($urandom_range(15, 0) == 0);
      cycle();
      if (last_grant >= 0) rq_valid[last_grant] = 1'b0;
    end
    hold = 1'b0;
    clr  = 1'b0;
    for (int i = 0; i < NREQ; i++) rq_valid[i] = 1'b0;
    repeat (2) cycle();
    for (int r = 0; r < 8; r++) chk("rf_final", 32'(tb_rf[r]), 32'(m_rf[r]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
